// File: rtl/mem_arbiter.sv
// Arbitrates one variable-latency memory port between IFU (read-only) and LSU (read/write), one transaction at a time.
// Latency: accept T, mem_req_valid T+1, resp_valid one cycle after mem response (min T+3); out-of-range addresses respond at T+1.
// Backpressure: requests wait in IDLE only; mem_req held stable until mem_req_ready; response held until owner's resp_ready.
module mem_arbiter #(
  parameter int unsigned       ADDR_W         = 64,
  parameter int unsigned       DATA_W         = 64,
  parameter logic [ADDR_W-1:0] MEM_BASE       = 'h8000_0000,
  parameter logic [ADDR_W-1:0] MEM_SIZE       = 'h10000,
  parameter int unsigned       MAX_LSU_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_req_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_resp_data,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_req_addr,
  input  logic                lsu_req_wen,
  input  logic [DATA_W-1:0]   lsu_req_wdata,
  input  logic [DATA_W/8-1:0] lsu_req_wstrb,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_resp_rdata,
  output logic                lsu_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_resp_rdata,
  output logic                busy,
  output logic                owner
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SW     = (MAX_LSU_STREAK < 1) ? 1 : $clog2(MAX_LSU_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETURN} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [SW-1:0]       streak_q, streak_d;

  // LSU wins ties unless it has already starved a waiting IFU for the full streak
  logic              sel_lsu, sel_ifu, addr_legal;
  logic [ADDR_W-1:0] sel_addr;
  assign sel_lsu    = lsu_req_valid && (!ifu_req_valid || (streak_q != STREAK_MAX));
  assign sel_ifu    = ifu_req_valid && !sel_lsu;
  assign sel_addr   = sel_lsu ? lsu_req_addr : ifu_req_addr;
  assign addr_legal = (sel_addr >= MEM_BASE) && ((sel_addr - MEM_BASE) < MEM_SIZE);

  // Next-state and handshake logic for the single-transaction FSM
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    addr_d         = addr_q;
    wen_d          = wen_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    streak_d       = streak_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_resp_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_lsu || sel_ifu) begin
          ifu_req_ready = sel_ifu;
          lsu_req_ready = sel_lsu;
          owner_d       = sel_lsu;
          addr_d        = sel_addr;
          wen_d         = sel_lsu && lsu_req_wen;
          wdata_d       = sel_lsu ? lsu_req_wdata : '0;
          wstrb_d       = sel_lsu ? lsu_req_wstrb : '0;
          rdata_d       = '0;
          if (sel_lsu && ifu_req_valid) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
          end else begin
            streak_d = '0;
          end
          if (addr_legal) begin
            err_d   = 1'b0;
            state_d = S_ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = S_RETURN;
          end
        end
      end
      S_ISSUE: begin
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        mem_resp_ready = 1'b1;
        if (mem_resp_valid) begin
          rdata_d = wen_q ? '0 : mem_resp_rdata;
          state_d = S_RETURN;
        end
      end
      S_RETURN: begin
        if (owner_q ? lsu_resp_ready : ifu_resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched transaction fields; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      streak_q <= streak_d;
    end
  end

  // Everything except req_ready comes from registers, so no mem_* input reaches a requester output
  assign mem_req_valid  = (state_q == S_ISSUE);
  assign mem_req_addr   = addr_q;
  assign mem_req_wen    = wen_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wstrb  = wstrb_q;
  assign ifu_resp_valid = (state_q == S_RETURN) && !owner_q;
  assign lsu_resp_valid = (state_q == S_RETURN) && owner_q;
  assign ifu_resp_data  = ifu_resp_valid ? rdata_q : '0;
  assign ifu_resp_err   = ifu_resp_valid && err_q;
  assign lsu_resp_rdata = lsu_resp_valid ? rdata_q : '0;
  assign lsu_resp_err   = lsu_resp_valid && err_q;
  assign busy           = (state_q != S_IDLE);
  assign owner          = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] SIZE = 64'h1_0000;
  localparam int MAX_STREAK = 4;

  logic        clk, rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
  logic [63:0] ifu_req_addr, ifu_resp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
  logic [63:0] lsu_req_addr, lsu_req_wdata, lsu_resp_rdata;
  logic [7:0]  lsu_req_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid, mem_resp_ready;
  logic [63:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
  logic [7:0]  mem_req_wstrb;
  logic        busy, owner;

  int checks = 0;
  int failures = 0;

  logic [63:0] mdl_mem [logic [63:0]];

  logic [274:0] all_outs;
  assign all_outs = {ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
                     lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
                     mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
                     mem_resp_ready, busy, owner};

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_rdata(mem_resp_rdata),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 0; ifu_req_addr = '0; ifu_resp_ready = 0;
    lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0; lsu_req_wdata = '0; lsu_req_wstrb = '0;
    lsu_resp_ready = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    step();
  endtask

  // Drive zero-wait memory and ready requesters until the arbiter returns to IDLE
  task automatic finish_txn();
    ifu_req_valid = 0; lsu_req_valid = 0;
    mem_req_ready = 1; mem_resp_valid = 1; mem_resp_rdata = '0;
    ifu_resp_ready = 1; lsu_resp_ready = 1;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      step();
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL finish_txn: busy=%b required 0 after 20 cycles", busy); end
    mem_resp_valid = 0;
  endtask

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (mdl_mem.exists(a)) return mdl_mem[a];
    return {~a[31:0], a[31:0]};
  endfunction

  function automatic logic [63:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 64'h1000 + 64'({$urandom_range(0, 15), 3'b000});
    if (r == 1) return BASE + SIZE + 64'({$urandom_range(0, 255), 3'b000});
    if (r == 2) return BASE + SIZE - 64'd8;
    return BASE + 64'({$urandom_range(0, 31), 3'b000});
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #2;
    checks++;
    if (all_outs !== '0) begin failures++; $display("FAIL reset_outs: got %h required 0", all_outs); end
    step();
    rst_n = 1;
    step();
    checks++;
    if (all_outs !== '0) begin failures++; $display("FAIL reset_idle: got %h required 0", all_outs); end
  endtask

  task automatic test_ifu_read(input logic [63:0] a, input logic [63:0] d);
    idle_inputs();
    ifu_resp_ready = 1; ifu_req_valid = 1; ifu_req_addr = a; mem_req_ready = 1;
    #1;
    checks++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin failures++; $display("FAIL ifu_accept: got %b required 10", {ifu_req_ready, lsu_req_ready}); end
    step();
    ifu_req_valid = 0; ifu_req_addr = '0;
    #1;
    checks++;
    if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wstrb, ifu_resp_valid} !== {1'b1, a, 1'b0, 8'h00, 1'b0}) begin
      failures++; $display("FAIL ifu_issue: vld=%b addr=%h wen=%b strb=%h rv=%b required 1 %h 0 00 0",
                           mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wstrb, ifu_resp_valid, a);
    end
    step();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = d;
    #1;
    checks++;
    if ({mem_resp_ready, ifu_resp_valid} !== 2'b10) begin failures++; $display("FAIL ifu_wait: got %b required 10", {mem_resp_ready, ifu_resp_valid}); end
    step();
    mem_resp_valid = 0; mem_resp_rdata = '0;
    #1;
    checks++;
    if ({ifu_resp_valid, ifu_resp_data, ifu_resp_err, owner, lsu_resp_valid} !== {1'b1, d, 1'b0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL ifu_resp: vld=%b data=%h err=%b owner=%b lsu_vld=%b required 1 %h 0 0 0",
                           ifu_resp_valid, ifu_resp_data, ifu_resp_err, owner, lsu_resp_valid, d);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL ifu_done: busy=%b required 0", busy); end
  endtask

  task automatic test_lsu_write_stall();
    logic [63:0] a = BASE + 64'h10;
    idle_inputs();
    lsu_resp_ready = 1; lsu_req_valid = 1; lsu_req_addr = a; lsu_req_wen = 1;
    lsu_req_wdata = 64'hDEAD_BEEF; lsu_req_wstrb = 8'h0F;
    #1;
    checks++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin failures++; $display("FAIL lsu_accept: got %b required 01", {ifu_req_ready, lsu_req_ready}); end
    step();
    lsu_req_valid = 0; lsu_req_wdata = 64'hFFFF_0000_FFFF_0000; lsu_req_wstrb = 8'hF0; lsu_req_addr = '0;
    for (int i = 0; i < 4; i++) begin
      mem_req_ready = (i == 3);
      mem_resp_valid = 1; mem_resp_rdata = 64'h1234;
      #1;
      checks++;
      if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb, mem_resp_ready} !==
          {1'b1, a, 1'b1, 64'hDEAD_BEEF, 8'h0F, 1'b0}) begin
        failures++; $display("FAIL lsu_stall%0d: vld=%b addr=%h wen=%b wdata=%h strb=%h rrdy=%b required 1 %h 1 deadbeef 0f 0",
                             i, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb, mem_resp_ready, a);
      end
      step();
    end
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    mem_resp_valid = 0;
    #1;
    checks++;
    if ({lsu_resp_valid, lsu_resp_rdata, lsu_resp_err, owner, ifu_resp_valid} !== {1'b1, 64'h0, 1'b0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL lsu_write_resp: vld=%b rdata=%h err=%b owner=%b ifu_vld=%b required 1 0 0 1 0",
                           lsu_resp_valid, lsu_resp_rdata, lsu_resp_err, owner, ifu_resp_valid);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL lsu_done: busy=%b required 0", busy); end
  endtask

  task automatic test_fairness();
    logic [9:0] g = '0;
    int n = 0;
    do_reset();
    ifu_req_valid = 1; ifu_req_addr = BASE + 64'h100;
    lsu_req_valid = 1; lsu_req_addr = BASE + 64'h200; lsu_req_wen = 0;
    mem_req_ready = 1; mem_resp_valid = 1; mem_resp_rdata = 64'h55;
    ifu_resp_ready = 1; lsu_resp_ready = 1;
    for (int c = 0; c < 80 && n < 10; c++) begin
      #1;
      if (ifu_req_ready || lsu_req_ready) begin
        g[n] = lsu_req_ready;
        n++;
      end
      step();
    end
    checks++;
    if (n != 10 || g !== 10'b01111_01111) begin
      failures++; $display("FAIL fairness_order: grants=%0d order(bit0 first,1=LSU)=%b required 10 %b", n, g, 10'b01111_01111);
    end
    finish_txn();
  endtask

  task automatic test_illegal();
    logic [63:0] t_addr [6] = '{64'h0000_1000, 64'h8001_0000, 64'h7FFF_FFF8,
                                64'hFFFF_FFFF_8000_0000, 64'h8000_FFF8, 64'h8000_0000};
    bit t_lsu [6] = '{0, 0, 1, 1, 0, 1};
    bit t_ok  [6] = '{0, 0, 0, 0, 1, 1};
    logic rv, ov, re;
    logic [63:0] rd;
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      ifu_resp_ready = 1; lsu_resp_ready = 1; mem_req_ready = 1;
      if (t_lsu[i]) begin lsu_req_valid = 1; lsu_req_addr = t_addr[i]; end
      else begin ifu_req_valid = 1; ifu_req_addr = t_addr[i]; end
      #1;
      checks++;
      if ({ifu_req_ready, lsu_req_ready} !== {!t_lsu[i], t_lsu[i]}) begin
        failures++; $display("FAIL range_accept%0d: got %b required %b", i, {ifu_req_ready, lsu_req_ready}, {!t_lsu[i], t_lsu[i]});
      end
      step();
      ifu_req_valid = 0; lsu_req_valid = 0;
      #1;
      rv = t_lsu[i] ? lsu_resp_valid : ifu_resp_valid;
      ov = t_lsu[i] ? ifu_resp_valid : lsu_resp_valid;
      rd = t_lsu[i] ? lsu_resp_rdata : ifu_resp_data;
      re = t_lsu[i] ? lsu_resp_err : ifu_resp_err;
      checks++;
      if ({mem_req_valid, rv, ov, re, rd} !== {t_ok[i], !t_ok[i], 1'b0, !t_ok[i], 64'h0}) begin
        failures++; $display("FAIL range%0d addr=%h: mvld=%b rvld=%b other=%b err=%b data=%h required %b %b 0 %b 0",
                             i, t_addr[i], mem_req_valid, rv, ov, re, rd, t_ok[i], !t_ok[i], !t_ok[i]);
      end
      if (t_ok[i]) finish_txn();
      else begin
        step();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL range_done%0d: busy=%b required 0", i, busy); end
      end
    end
  endtask

  task automatic test_resp_backpressure();
    idle_inputs();
    lsu_req_valid = 1; lsu_req_addr = BASE + 64'h100; lsu_req_wen = 0;
    step();
    lsu_req_valid = 0; mem_req_ready = 1;
    step();
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 64'hA5A5_5A5A_0F0F_F0F0;
    step();
    mem_resp_valid = 0; mem_resp_rdata = '0;
    ifu_req_valid = 1; ifu_req_addr = BASE + 64'h200;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({lsu_resp_valid, lsu_resp_rdata, lsu_resp_err, ifu_req_ready, lsu_req_ready, ifu_resp_valid} !==
          {1'b1, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 3'b000}) begin
        failures++; $display("FAIL hold%0d: vld=%b rdata=%h err=%b irdy=%b lrdy=%b ivld=%b required 1 a5a55a5a0f0ff0f0 0 0 0 0",
                             i, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err, ifu_req_ready, lsu_req_ready, ifu_resp_valid);
      end
      step();
    end
    lsu_resp_ready = 1;
    #1;
    checks++;
    if (ifu_req_ready !== 1'b0) begin failures++; $display("FAIL no_back_to_back: ifu_req_ready=%b required 0", ifu_req_ready); end
    step();
    #1;
    checks++;
    if (ifu_req_ready !== 1'b1) begin failures++; $display("FAIL next_grant: ifu_req_ready=%b required 1", ifu_req_ready); end
    step();
    finish_txn();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    ifu_req_valid = 1; ifu_req_addr = BASE + 64'h40;
    step();
    ifu_req_valid = 0; mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    #1;
    checks++;
    if ({busy, mem_resp_ready} !== 2'b11) begin failures++; $display("FAIL mid_in_wait: busy/rrdy=%b required 11", {busy, mem_resp_ready}); end
    #1;
    rst_n = 0;
    #1;
    checks++;
    if (all_outs !== '0) begin failures++; $display("FAIL mid_reset_outs: got %h required 0", all_outs); end
    step(); step();
    #2;
    rst_n = 1;
    step();
    mem_resp_valid = 1; mem_resp_rdata = 64'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (all_outs !== '0) begin failures++; $display("FAIL late_resp%0d: got %h required 0", i, all_outs); end
      step();
    end
    test_ifu_read(BASE + 64'h48, 64'h0123_4567_89AB_CDEF);
  endtask

  task automatic test_random(input int n_cycles);
    bit ifu_pend = 0, lsu_pend = 0, active = 0, issue_pend = 0, wait_pend = 0, resp_pend = 0;
    bit exp_owner = 0, exp_err = 0, exp_wen = 0, exp_i, exp_l;
    logic [63:0] exp_addr = '0, exp_wdata = '0, exp_data = '0, mem_data = '0, cur, sel_a;
    logic [7:0]  exp_wstrb = '0;
    int streak = 0, mem_cnt = 0, done = 0;
    do_reset();
    for (int c = 0; c < n_cycles + 300; c++) begin
      if (!ifu_pend && c < n_cycles && $urandom_range(0, 2) != 0) begin
        ifu_pend = 1; ifu_req_addr = rand_addr();
      end
      if (!lsu_pend && c < n_cycles && $urandom_range(0, 2) != 0) begin
        lsu_pend = 1; lsu_req_addr = rand_addr(); lsu_req_wen = 1'($urandom_range(0, 1));
        lsu_req_wdata = {$urandom, $urandom}; lsu_req_wstrb = 8'($urandom);
      end
      ifu_req_valid = ifu_pend; lsu_req_valid = lsu_pend;
      mem_req_ready = 1'($urandom_range(0, 1));
      mem_resp_valid = 0; mem_resp_rdata = {$urandom, $urandom};
      if (wait_pend) begin
        if (mem_cnt == 0) begin mem_resp_valid = 1; mem_resp_rdata = mem_data; end
        else mem_cnt--;
      end
      ifu_resp_ready = 1'($urandom_range(0, 1));
      lsu_resp_ready = 1'($urandom_range(0, 1));
      #1;
      exp_l = !active && lsu_pend && (!ifu_pend || streak != MAX_STREAK);
      exp_i = !active && ifu_pend && !exp_l;
      checks++;
      if ({ifu_req_ready, lsu_req_ready} !== {exp_i, exp_l}) begin
        failures++; $display("FAIL rnd_grant c=%0d: rdy=%b required %b", c, {ifu_req_ready, lsu_req_ready}, {exp_i, exp_l});
      end
      checks++;
      if ({busy, mem_req_valid, mem_resp_ready} !== {active, issue_pend, wait_pend}) begin
        failures++; $display("FAIL rnd_state c=%0d: busy/mvld/rrdy=%b required %b", c,
                             {busy, mem_req_valid, mem_resp_ready}, {active, issue_pend, wait_pend});
      end
      if (active) begin
        checks++;
        if (owner !== exp_owner) begin failures++; $display("FAIL rnd_owner c=%0d: got %b required %b", c, owner, exp_owner); end
      end
      if (issue_pend) begin
        checks++;
        if ({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb} !== {exp_addr, exp_wen, exp_wdata, exp_wstrb}) begin
          failures++; $display("FAIL rnd_memreq c=%0d: got %h %b %h %h required %h %b %h %h", c, mem_req_addr, mem_req_wen,
                               mem_req_wdata, mem_req_wstrb, exp_addr, exp_wen, exp_wdata, exp_wstrb);
        end
      end
      checks++;
      if ({ifu_resp_valid, lsu_resp_valid} !== (resp_pend ? (exp_owner ? 2'b01 : 2'b10) : 2'b00)) begin
        failures++; $display("FAIL rnd_respvld c=%0d: got %b pending=%b owner=%b", c, {ifu_resp_valid, lsu_resp_valid}, resp_pend, exp_owner);
      end
      if (resp_pend) begin
        checks++;
        if ((exp_owner ? {lsu_resp_rdata, lsu_resp_err} : {ifu_resp_data, ifu_resp_err}) !== {exp_data, exp_err}) begin
          failures++; $display("FAIL rnd_resp c=%0d owner=%b: got %h/%b %h/%b required %h/%b", c, exp_owner,
                               ifu_resp_data, ifu_resp_err, lsu_resp_rdata, lsu_resp_err, exp_data, exp_err);
        end
      end
      if (exp_i || exp_l) begin
        sel_a     = exp_l ? lsu_req_addr : ifu_req_addr;
        active    = 1;
        exp_owner = exp_l;
        exp_addr  = sel_a;
        exp_wen   = exp_l && lsu_req_wen;
        exp_wdata = exp_l ? lsu_req_wdata : '0;
        exp_wstrb = exp_l ? lsu_req_wstrb : '0;
        if (exp_l) streak = ifu_pend ? ((streak < MAX_STREAK) ? streak + 1 : streak) : 0;
        else streak = 0;
        if (exp_l) lsu_pend = 0; else ifu_pend = 0;
        if (sel_a >= BASE && sel_a < BASE + SIZE) issue_pend = 1;
        else begin resp_pend = 1; exp_err = 1; exp_data = '0; end
      end else if (issue_pend && mem_req_ready) begin
        issue_pend = 0; wait_pend = 1; exp_err = 0;
        mem_cnt = int'($urandom_range(0, 3));
        cur = mem_rd(exp_addr);
        if (exp_wen) begin
          for (int b = 0; b < 8; b++) if (exp_wstrb[b]) cur[b*8 +: 8] = exp_wdata[b*8 +: 8];
          mdl_mem[exp_addr] = cur;
          mem_data = {$urandom, $urandom};
          exp_data = '0;
        end else begin
          mem_data = cur;
          exp_data = cur;
        end
      end else if (wait_pend && mem_resp_valid) begin
        wait_pend = 0; resp_pend = 1;
      end else if (resp_pend && (exp_owner ? lsu_resp_ready : ifu_resp_ready)) begin
        resp_pend = 0; active = 0; done++;
      end
      step();
    end
    checks++;
    if (active || ifu_pend || lsu_pend || done < 50) begin
      failures++; $display("FAIL rnd_drain: active=%b ifu_pend=%b lsu_pend=%b completed=%0d required idle with >=50 completed",
                           active, ifu_pend, lsu_pend, done);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_ifu_read(64'h8000_0008, 64'h1122_3344_5566_7788);
    test_lsu_write_stall();
    test_fairness();
    test_illegal();
    test_resp_backpressure();
    test_reset_mid();
    test_random(2000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
